// File: rtl/universal_shift_reg_n.sv
// ---------------------------------------------------------------------------
// universal_shift_reg_n
//
// Parametrised universal shift register with multi-step shift/rotate
// operations under a start/busy/done handshake.
//
// Handshake: a request is accepted on a rising edge where start=1, busy=0
// and rst=1. Single-cycle operations (HOLD, LOAD, reserved, amt=0) and
// one-step shifts complete on the accept edge; longer shifts hold busy high
// until the edge that executes the last step. done pulses for exactly one
// cycle after each completion, and a new start may be issued in that cycle.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-low reset
//   start  in   1      operation request (sampled while busy=0)
//   mode   in   3      operation select, latched on accept
//   amt    in   AW     number of single-bit steps, latched on accept
//   pin    in   WIDTH  parallel load data
//   sin_r  in   1      serial bit entering the MSB on a logical right shift
//   sin_l  in   1      serial bit entering the LSB on a left shift
//   pout   out  WIDTH  register contents
//   sout   out  1      bit expelled by the most recent step
//   busy   out  1      multi-step operation in progress (FSM is in RUN)
//   done   out  1      one-cycle completion pulse
// ---------------------------------------------------------------------------
module universal_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] pin,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] pout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_cnt;    // steps still to execute after the current edge
    logic [2:0]       r_mode;
    logic [WIDTH-1:0] r_pout;
    logic             r_sout;
    logic             r_done;

    logic [2:0]       w_cur_mode;
    logic             w_is_shift;
    logic [WIDTH-1:0] w_step_val;
    logic             w_step_bit;

    // The first step runs on the accept edge, before mode is latched, so the
    // step logic looks at the live mode input in IDLE and the latched one in RUN.
    assign w_cur_mode = (r_state == ST_RUN) ? r_mode : mode;

    always_comb begin
        w_is_shift = 1'b0;
        w_step_val = r_pout;
        w_step_bit = r_sout;
        case (w_cur_mode)
            MODE_SHR: begin
                w_is_shift = 1'b1;
                w_step_val = {sin_r, r_pout[WIDTH-1:1]};
                w_step_bit = r_pout[0];
            end
            MODE_SHL: begin
                w_is_shift = 1'b1;
                w_step_val = {r_pout[WIDTH-2:0], sin_l};
                w_step_bit = r_pout[WIDTH-1];
            end
            MODE_ROR: begin
                w_is_shift = 1'b1;
                w_step_val = {r_pout[0], r_pout[WIDTH-1:1]};
                w_step_bit = r_pout[0];
            end
            MODE_ROL: begin
                w_is_shift = 1'b1;
                w_step_val = {r_pout[WIDTH-2:0], r_pout[WIDTH-1]};
                w_step_bit = r_pout[WIDTH-1];
            end
            MODE_ASR: begin
                w_is_shift = 1'b1;
                w_step_val = {r_pout[WIDTH-1], r_pout[WIDTH-1:1]};
                w_step_bit = r_pout[0];
            end
            default: begin
                // HOLD, LOAD and reserved are not step operations.
                w_is_shift = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= MODE_HOLD;
            r_pout  <= '0;
            r_sout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        if (w_is_shift && (amt != '0)) begin
                            r_pout <= w_step_val;
                            r_sout <= w_step_bit;
                            if (amt == AW'(1)) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= ST_RUN;
                                r_cnt   <= amt - AW'(1);
                            end
                        end else begin
                            if (mode == MODE_LOAD) begin
                                r_pout <= pin;
                            end
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_pout <= w_step_val;
                    r_sout <= w_step_bit;
                    r_cnt  <= r_cnt - AW'(1);
                    // cnt==1 means this edge executes the final step.
                    if (r_cnt == AW'(1)) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pout = r_pout;
    assign sout = r_sout;
    assign busy = (r_state == ST_RUN);
    assign done = r_done;

endmodule

// File: doc/universal_shift_reg_n.md
# universal_shift_reg_n

Parametrised universal shift register, successor to the fixed 4-bit universal shift register. It adds configurable width, serial inputs and output, rotate and arithmetic-shift modes, and multi-step shift-by-N operations under a start/busy/done handshake. It sits between byte-level datapath logic and serial links, serialising, deserialising and realigning words.

## Interface

Parameters:
- WIDTH, 8: register width (≥2).
- AW, $clog2(WIDTH+1): width of the shift-amount input.

Ports (synchronous active-low reset on every port-facing register):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  operation request; sampled only while busy=0.
- mode  in  3  operation select, latched on accept.
- amt  in  AW  number of single-bit steps, latched on accept.
- pin  in  WIDTH  parallel load data.
- sin_r  in  1  serial input entering the MSB on a logical right shift; sampled live on each step.
- sin_l  in  1  serial input entering the LSB on a left shift; sampled live on each step.
- pout  out  WIDTH  register contents.
- sout  out  1  bit expelled by the most recent step.
- busy  out  1  multi-step operation in progress.
- done  out  1  one-cycle completion pulse.

## Operation

Modes:
- 000 HOLD: no change.
- 001 SHR: logical right shift; sin_r enters the MSB; the LSB is expelled.
- 010 SHL: left shift; sin_l enters the LSB; the MSB is expelled.
- 011 LOAD: pout<=pin; amt is ignored.
- 100 ROR: rotate right; the expelled bit is the old LSB.
- 101 ROL: rotate left; the expelled bit is the old MSB.
- 110 ASR: arithmetic right shift; the MSB is replicated; the LSB is expelled.
- 111: reserved; treated as HOLD.

State machine:
- Two states: IDLE and RUN.
- A remaining-step counter `cnt` (AW bits) drives the state: busy = (state==RUN).

Accepting a request:
- The request is accepted at edge T if start=1, busy=0 and rst=1.
- On accept, latch mode and amt.

Completing on the accept edge:
- Applies when the mode is HOLD, LOAD or reserved, or when amt=0.
- The action is applied at edge T; the FSM stays in IDLE.
- done=1 for the cycle after edge T.
- HOLD and amt=0 leave pout and sout unchanged.

Multi-step shift or rotate (amt=k≥1):
- The first step executes at edge T; steps continue one per edge through T+k−1.
- For k≥2: enter RUN at T with cnt=k−1; decrement cnt on each step; return to IDLE on the edge where the last step executes.
- done=1 for the cycle after the final step.
- amt is not clamped: amt>WIDTH executes amt steps. ROR/ROL wrap naturally; SHR/SHL flush in serial bits.

Register updates:
- sout updates on every executed step and holds otherwise. LOAD does not change sout.
- done is 0 in every cycle except one following an operation completion.

Boundary behaviour:
- start while busy=1: ignored; no queuing.
- Changes to pin, mode or amt during RUN: ignored. sin_r/sin_l are the only live inputs.
- start asserted in the cycle where done=1 (busy=0): accepted. Back-to-back operations have no idle gap.
- Reset mid-operation (rst=0 at any edge):
  - pout=0, sout=0, busy=0, done=0, cnt=0, state IDLE.
  - No done pulse for the aborted operation.
  - start is ignored while rst=0.

## Timing

- Reset values: pout=0, sout=0, busy=0, done=0.
- Latency: HOLD, LOAD, reserved and amt=0 complete in 1 cycle. A shift/rotate of k steps completes in k cycles.
- busy is high for k−1 cycles (never high for k≤1).
- done rises in the same cycle busy falls.
- pout is registered; the new value is visible in the cycle after each step edge.
- Throughput: one operation per max(1,k) cycles.

## Test plan

All scenarios use WIDTH=8.

- **Reset and load:** rst=0 for 2 cycles, then release and LOAD pin=8'hA5.
  - During reset: pout=0x00, sout=0, busy=0, done=0.
  - After the load edge: pout=0xA5, done=1 for exactly 1 cycle, busy never 1.
- **Logical shift right:** from 0xA5, SHR amt=3 with sin_r=0.
  - pout: 0x52, 0x29, 0x14.
  - busy=1 for 2 cycles; done=1 in the cycle pout=0x14.
  - sout=1.
- **Rotate and arithmetic shift:**
  - From 0xA5, ROL amt=4 → pout=0x5A.
  - Then LOAD 0x90 and ASR amt=2 → pout=0xE4, sout=0.
- **Full serial fill:** from 0x00, SHL amt=8 with sin_l=1.
  - pout: 0x01, 0x03, …, 0xFF.
  - done occurs 8 cycles after accept; sout=0.
- **Ignored inputs and back-to-back:**
  - During an SHR amt=4, pulse start with LOAD 0xFF and change pin/mode/amt; result is unaffected.
  - HOLD and amt=0 each give a 1-cycle done with pout unchanged.
  - A start issued in the done cycle is accepted.
- **Abort:** during ROR amt=6, assert rst=0 at step 3.
  - Next cycle: pout=0, busy=0, done=0, sout=0.
  - No late done pulse.
  - A fresh LOAD 0x3C after release completes normally.
